// File: rtl/nolinear_pwl.sv
`default_nettype none
// ============================================================================
// nolinear_pwl : per-lane piecewise-linear y = (a*x >>> Bf) + b, 3-stage pipe.
// Option macro NOLINEAR_PWL_SAT_EN selects clamp+flag instead of wrap. Rev 1.0
// ============================================================================
module nolinear_pwl #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int Bf              = 8,
  parameter int DATA_NUM        = 4,
  parameter int SEG_BITS        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_mode,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out,
  output logic [DATA_NUM-1:0]               sat_flag,
  input  logic                              coef_we,
  input  logic [1:0]                        coef_mode,
  input  logic [SEG_BITS-1:0]               coef_seg,
  input  logic [FIX_POINT_WIDTH-1:0]        coef_a,
  input  logic [FIX_POINT_WIDTH-1:0]        coef_b
);

  localparam int W       = FIX_POINT_WIDTH;
  localparam int IDX_W   = SEG_BITS + 2;
  localparam int ENTRIES = 1 << IDX_W;

  logic [W-1:0] tab_a [ENTRIES];
  logic [W-1:0] tab_b [ENTRIES];

  logic                  adv;
  logic                  v1, v2, v3;
  logic [W-1:0]          x1 [DATA_NUM];
  logic [W-1:0]          a1 [DATA_NUM];
  logic [W-1:0]          b1 [DATA_NUM];
  logic signed [2*W-1:0] p2 [DATA_NUM];
  logic [W-1:0]          b2 [DATA_NUM];
  logic [W-1:0]          y3 [DATA_NUM];
  logic [DATA_NUM-1:0]   sat3;
  logic [IDX_W-1:0]      idx [DATA_NUM];
  logic [W-1:0]          y_next [DATA_NUM];
  logic [DATA_NUM-1:0]   sat_next;

  // Whole pipeline moves as one; only the output stage can block it.
  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign sat_flag  = sat3;

  // Same-edge write and lookup naturally return the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        tab_a[e] <= '0;
        tab_b[e] <= '0;
      end
    end else if (coef_we) begin
      tab_a[{coef_mode, coef_seg}] <= coef_a;
      tab_b[{coef_mode, coef_seg}] <= coef_b;
    end
  end

  for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
    logic [W-1:0] x_in;
    assign x_in   = in[i*W +: W];
    assign idx[i] = {in_mode, ~x_in[W-1], x_in[W-2 -: SEG_BITS-1]};
    assign out[i*W +: W] = y3[i];

`ifdef NOLINEAR_PWL_SAT_EN
    localparam int SW = 2*W - Bf + 1;
    logic signed [SW-1:0] sum;
    logic                 ovf;
    assign sum = SW'(p2[i] >>> Bf) + SW'($signed(b2[i]));
    // In range exactly when all bits from W-1 upward agree with the sign.
    assign ovf = ~((&sum[SW-1:W-1]) | ~(|sum[SW-1:W-1]));
    assign y_next[i]   = ovf ? (sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                             : sum[W-1:0];
    assign sat_next[i] = ovf;
`else
    assign y_next[i]   = W'(p2[i] >>> Bf) + b2[i];
    assign sat_next[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      sat3 <= '0;
      for (int l = 0; l < DATA_NUM; l++) begin
        y3[l] <= '0;
      end
    end else if (adv) begin
      v1   <= in_valid;
      v2   <= v1;
      v3   <= v2;
      sat3 <= sat_next;
      for (int l = 0; l < DATA_NUM; l++) begin
        x1[l] <= in[l*W +: W];
        a1[l] <= tab_a[idx[l]];
        b1[l] <= tab_b[idx[l]];
        p2[l] <= (2*W)'($signed(a1[l])) * (2*W)'($signed(x1[l]));
        b2[l] <= b1[l];
        y3[l] <= y_next[l];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nolinear_pwl.sv
`default_nettype none
// tb_nolinear_pwl : directed vectors with a scoreboard model of the PWL math.
module tb_nolinear_pwl;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [N*W-1:0] in;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out;
  logic [N-1:0]   sat_flag;
  logic           coef_we;
  logic [1:0]     coef_mode;
  logic [3:0]     coef_seg;
  logic [W-1:0]   coef_a;
  logic [W-1:0]   coef_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nolinear_pwl #(
    .FIX_POINT_WIDTH(16),
    .Bf(8),
    .DATA_NUM(4),
    .SEG_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in(in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .sat_flag(sat_flag),
    .coef_we(coef_we),
    .coef_mode(coef_mode),
    .coef_seg(coef_seg),
    .coef_a(coef_a),
    .coef_b(coef_b)
  );

  // ---------------- model ----------------
  typedef struct {
    logic [N*W-1:0] y;
    logic [N-1:0]   s;
  } exp_t;

  int   ma [4][16];
  int   mb [4][16];
  exp_t q[$];

  function automatic exp_t model_beat(input logic [1:0] m, input logic [N*W-1:0] xs);
    exp_t   e;
    longint p;
    longint r;
    int     x;
    int     seg;
    for (int l = 0; l < N; l++) begin
      x   = int'($signed(xs[l*W +: W]));
      seg = (x + 32768) / 4096;
      p   = longint'(ma[m][seg]) * longint'(x);
      r   = (p >>> 8) + longint'(mb[m][seg]);
`ifdef NOLINEAR_PWL_SAT_EN
      if (r > 32767) begin
        e.y[l*W +: W] = 16'h7FFF;
        e.s[l]        = 1'b1;
      end else if (r < -32768) begin
        e.y[l*W +: W] = 16'h8000;
        e.s[l]        = 1'b1;
      end else begin
        e.y[l*W +: W] = r[15:0];
        e.s[l]        = 1'b0;
      end
`else
      e.y[l*W +: W] = r[15:0];
      e.s[l]        = 1'b0;
`endif
    end
    return e;
  endfunction

  logic [N*W-1:0] prev_out;
  logic [N-1:0]   prev_sat;
  bit             prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      for (int m = 0; m < 4; m++)
        for (int s = 0; s < 16; s++) begin
          ma[m][s] = 0;
          mb[m][s] = 0;
        end
    end else begin
      if (prev_stall) begin
        total++;
        if (out !== prev_out || sat_flag !== prev_sat) begin
          bad++;
          $display("FAIL stall_hold out=%h sat=%h required out=%h sat=%h", out, sat_flag, prev_out, prev_sat);
        end
      end
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat out=%h sat=%h required no beat", out, sat_flag);
        end else begin
          e = q[0];
          if (out !== e.y || sat_flag !== e.s) begin
            bad++;
            $display("FAIL model_beat out=%h sat=%h required out=%h sat=%h", out, sat_flag, e.y, e.s);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_sat   = sat_flag;
      if (in_valid && in_ready) q.push_back(model_beat(in_mode, in));
      if (coef_we) begin
        ma[coef_mode][coef_seg] = int'($signed(coef_a));
        mb[coef_mode][coef_seg] = int'($signed(coef_b));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] m, input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    coef_we   = 1'b1;
    coef_mode = m;
    coef_seg  = s;
    coef_a    = a;
    coef_b    = b;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [15:0] y);
    int n = 0;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_out"}, out, {N{y}});
    tick();
  endtask

  task automatic send_wait(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                           input logic [3:0] s, input string name);
    int lat;
    in_mode   = m;
    in        = {N{x}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_out"}, out, {N{y}});
    chk({name, "_sat"}, sat_flag, s);
    tick();
  endtask

  task automatic backpressure();
    int sent = 0;
    bit acc;
    in_mode = 2'd1;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c < 10);
      in_valid  = (sent < 6);
      for (int l = 0; l < N; l++) in[l*W +: W] = 16'(16'h0100 + sent * 16'h0040 + l * 4);
      #2;
      if (c >= 5 && c < 10) chk("bp_in_ready_low", in_ready, 0);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", sent, 6);
    chk("bp_drained", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in        = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_mode = 2'd0;
    coef_seg  = 4'd0;
    coef_a    = '0;
    coef_b    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_in_ready", in_ready, 1);

    wr(2'd1, 4'd8, 16'h0100, 16'h0000);
    send_wait(2'd1, 16'h0180, 16'h0180, 4'h0, "identity");

    wr(2'd2, 4'd8, 16'h0080, 16'h0100);
    wr(2'd2, 4'd7, 16'h0100, 16'h0000);
    send_wait(2'd2, 16'h0200, 16'h0200, 4'h0, "affine_seg8");
    send_wait(2'd2, 16'hFF00, 16'hFF00, 4'h0, "affine_seg7");
    send_wait(2'd0, 16'hFF00, 16'h0000, 4'h0, "unwritten_bank");

    wr(2'd3, 4'd15, 16'h7FFF, 16'h7FFF);
`ifdef NOLINEAR_PWL_SAT_EN
    send_wait(2'd3, 16'h7F00, 16'h7FFF, 4'hF, "saturate");
`else
    send_wait(2'd3, 16'h7F00, 16'hFF80, 4'h0, "wrap");
`endif

    backpressure();

    // Write hazard: lookup and write of the same entry on one edge.
    out_ready = 1'b1;
    in_mode   = 2'd1;
    in        = {N{16'h0100}};
    in_valid  = 1'b1;
    coef_we   = 1'b1;
    coef_mode = 2'd1;
    coef_seg  = 4'd8;
    coef_a    = 16'h0200;
    coef_b    = 16'h0000;
    tick();
    coef_we = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out("hazard_old", 16'h0100);
    wait_out("hazard_new", 16'h0200);

    // Reset with two beats in flight, plus a coefficient write that must be ignored.
    in_mode  = 2'd1;
    in       = {N{16'h0100}};
    in_valid = 1'b1;
    tick();
    tick();
    in_valid  = 1'b0;
    rst       = 1'b1;
    coef_we   = 1'b1;
    coef_mode = 2'd1;
    coef_seg  = 4'd8;
    coef_a    = 16'h0100;
    coef_b    = 16'h0100;
    tick();
    rst     = 1'b0;
    coef_we = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_no_beat", out_valid, 0);
    end
    send_wait(2'd1, 16'h0180, 16'h0000, 4'h0, "cleared_m1");
    send_wait(2'd2, 16'h0200, 16'h0000, 4'h0, "cleared_m2");

    repeat (3) tick();
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
